// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Purpose  : Signed 64-bit dot-product accumulator that sums a stream of
//            products into a result and offers it through a valid/ready
//            handshake.
//            Optional macro MAC_SAT_EN: when defined, overflowing sums
//            saturate to the most positive or most negative value.
//            When it is not defined, overflowing sums wrap modulo 2^64.
//            In both builds the sticky ovf flag is set on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             prod_valid,
   input  logic [63:0]      prod,
   output logic [63:0]      acc_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             ovf,
   output logic             drop
);

   localparam logic [LEN_W-1:0] c_LEN_ZERO = '0;
   localparam logic [LEN_W-1:0] c_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [63:0]      c_SAT_POS  = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0]      c_SAT_NEG  = 64'h8000_0000_0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t           r_state;
   logic [63:0]      r_acc;
   logic [LEN_W-1:0] r_count;
   logic [LEN_W-1:0] r_len;
   logic             r_out_valid;
   logic             r_busy;
   logic             r_ovf;
   logic             r_drop;

   logic [63:0]      w_sum;
   logic             w_add_ovf;
   logic [63:0]      w_next_acc;
   logic             w_last;

   // Raw sum plus signed-overflow detection: the addends agree in sign but
   // the result does not.
   always_comb begin
      w_sum      = r_acc + prod;
      w_add_ovf  = (r_acc[63] == prod[63]) && (w_sum[63] != r_acc[63]);
      w_next_acc = w_sum;
`ifdef MAC_SAT_EN
      if (w_add_ovf) begin
         // Both addends share a sign, so r_acc's sign gives the direction.
         w_next_acc = r_acc[63] ? c_SAT_NEG : c_SAT_POS;
      end
`endif
      w_last     = (r_count == (r_len - c_LEN_ONE));
   end

   // Control FSM with all outputs registered. Reset discards any partial
   // result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_len       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_ovf       <= 1'b0;
         r_drop      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (prod_valid) begin
                  r_drop <= 1'b1;
               end
               if (start) begin
                  r_acc   <= '0;
                  r_count <= '0;
                  r_len   <= len;
                  r_ovf   <= 1'b0;
                  r_drop  <= 1'b0;
                  r_busy  <= 1'b1;
                  if (len == c_LEN_ZERO) begin
                     // An empty dot product goes straight to presenting 0.
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state     <= S_ACCUM;
                     r_out_valid <= 1'b0;
                  end
               end
            end

            S_ACCUM: begin
               if (prod_valid) begin
                  r_acc   <= w_next_acc;
                  r_count <= r_count + c_LEN_ONE;
                  if (w_add_ovf) begin
                     r_ovf <= 1'b1;
                  end
                  if (w_last) begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                  end
               end
            end

            S_HOLD: begin
               if (prod_valid) begin
                  r_drop <= 1'b1;
               end
               // A start arriving here is ignored; it is accepted only in
               // IDLE.
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign acc_out   = r_acc;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign ovf       = r_ovf;
   assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Purpose  : Directed stimulus with a result scoreboard. Expected results
//            are queued at issue time and popped by a monitor on each output
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic        prod_valid;
   logic [63:0] prod;
   logic [63:0] acc_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        ovf;
   logic        drop;

   typedef struct {
      logic [63:0] acc;
      logic        ovf;
      logic        drop;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   mac_accumulator #(.LEN_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .prod_valid (prod_valid),
      .prod       (prod),
      .acc_out    (acc_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .ovf        (ovf),
      .drop       (drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic o, input logic d);
      exp_t e;
      e.acc  = a;
      e.ovf  = o;
      e.drop = d;
      exp_q.push_back(e);
   endtask

   // Complete the handshake on the presented result.
   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("valid_low_after_handshake", {63'd0, out_valid}, 64'd0);
   endtask

   // Monitor: every accepted result must match the oldest expected entry.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_acc_out", acc_out, e.acc);
            chk("sb_ovf", {63'd0, ovf}, {63'd0, e.ovf});
            chk("sb_drop", {63'd0, drop}, {63'd0, e.drop});
         end
      end
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      len        = '0;
      prod_valid = 1'b0;
      prod       = '0;
      out_ready  = 1'b0;
      tick();
      tick();
      chk("rst_acc_out", acc_out, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
      chk("rst_drop", {63'd0, drop}, 64'd0);
      rst = 1'b0;
      tick();

      // len=3 with products 5, -2, 10 back to back gives 13.
      start = 1'b1; len = 16'd3;
      tick();
      start = 1'b0;
      chk("busy_in_accum", {63'd0, busy}, 64'd1);
      prod_valid = 1'b1; prod = 64'd5;
      tick();
      prod = -64'sd2;
      tick();
      chk("valid_before_last", {63'd0, out_valid}, 64'd0);
      prod = 64'd10;
      tick();
      prod_valid = 1'b0;
      chk("valid_after_last", {63'd0, out_valid}, 64'd1);
      push(64'd13, 1'b0, 1'b0);
      release_result();

      // len=2 with a four-cycle gap; then backpressure for five cycles.
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      prod_valid = 1'b1; prod = 64'd5;
      tick();
      prod_valid = 1'b0;
      repeat (4) tick();
      chk("valid_during_gap", {63'd0, out_valid}, 64'd0);
      prod_valid = 1'b1; prod = 64'd7;
      tick();
      prod_valid = 1'b0;
      push(64'd12, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_acc_out", acc_out, 64'd12);
      end
      release_result();

      // len=0 presents 0 at once; a stray product in HOLD sets drop.
      start = 1'b1; len = 16'd0;
      tick();
      start = 1'b0;
      chk("empty_valid", {63'd0, out_valid}, 64'd1);
      chk("empty_acc", acc_out, 64'd0);
      prod_valid = 1'b1; prod = 64'd99;
      tick();
      prod_valid = 1'b0;
      chk("drop_in_hold", {63'd0, drop}, 64'd1);
      chk("acc_after_drop", acc_out, 64'd0);
      push(64'd0, 1'b0, 1'b1);
      // A start coincident with the handshake must be ignored.
      start = 1'b1; len = 16'd1;
      release_result();
      start = 1'b0;
      chk("start_in_hold_ignored", {63'd0, busy}, 64'd0);

      // Positive overflow.
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      chk("drop_cleared_on_start", {63'd0, drop}, 64'd0);
      prod_valid = 1'b1; prod = 64'h7FFF_FFFF_FFFF_FFFF;
      tick();
      prod = 64'd1;
      tick();
      prod_valid = 1'b0;
`ifdef MAC_SAT_EN
      push(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
`else
      push(64'h8000_0000_0000_0000, 1'b1, 1'b0);
`endif
      release_result();

      // Negative overflow.
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      chk("ovf_cleared_on_start", {63'd0, ovf}, 64'd0);
      prod_valid = 1'b1; prod = 64'h8000_0000_0000_0000;
      tick();
      prod = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      prod_valid = 1'b0;
`ifdef MAC_SAT_EN
      push(64'h8000_0000_0000_0000, 1'b1, 1'b0);
`else
      push(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
`endif
      release_result();

      // Reset after 2 of 4 products, then len=1 with -9.
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0;
      prod_valid = 1'b1; prod = 64'd3;
      tick();
      prod = 64'd4;
      tick();
      prod_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst_acc", acc_out, 64'd0);
      chk("async_rst_busy", {63'd0, busy}, 64'd0);
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      #1;
      rst = 1'b0;
      tick();
      start = 1'b1; len = 16'd1;
      tick();
      start = 1'b0;
      prod_valid = 1'b1; prod = -64'sd9;
      tick();
      prod_valid = 1'b0;
      push(-64'sd9, 1'b0, 1'b0);
      release_result();

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         tick();
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
